// File: rtl/fc_pkg.sv
// Shared types for the fc layer-chain sequencer: controller states and job mode.
package fc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        BWD  = 2'd2,
        DONE = 2'd3
    } fc_state_t;

    typedef enum logic {
        INFER = 1'b0,
        TRAIN = 1'b1
    } fc_mode_t;

endpackage

// File: rtl/layer_step_counter.sv
// Nested settle/layer counter walking the layer chain up or down, SETTLE cycles per layer.
module layer_step_counter #(
    parameter int LAYERS = 4,
    parameter int SETTLE = 2,
    parameter int LW     = $clog2(LAYERS) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic          down_i,
    input  logic          en_i,
    output logic [LW-1:0] layer_o,
    output logic          last_step_o
);

    localparam int            SW         = $clog2(SETTLE) + 1;
    localparam logic [SW-1:0] SETTLE_END = SW'(SETTLE - 1);
    localparam logic [LW-1:0] LAYER_TOP  = LW'(LAYERS - 1);

    logic [SW-1:0] settle_q, settle_d;
    logic [LW-1:0] layer_q, layer_d;
    logic          down_q, down_d;
    logic          settle_end, layer_end;

    assign settle_end  = (settle_q == SETTLE_END);
    assign layer_end   = down_q ? (layer_q == '0) : (layer_q == LAYER_TOP);
    assign last_step_o = settle_end && layer_end;
    assign layer_o     = layer_q;

    // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        settle_d = settle_q;
        layer_d  = layer_q;
        down_d   = down_q;
        if (load_i) begin
            settle_d = '0;
            down_d   = down_i;
            layer_d  = down_i ? LAYER_TOP : '0;
        end else if (en_i) begin
            if (settle_end) begin
                settle_d = '0;
                if (!layer_end) layer_d = down_q ? layer_q - LW'(1) : layer_q + LW'(1);
            end else begin
                settle_d = settle_q + SW'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            settle_q <= '0;
            layer_q  <= '0;
            down_q   <= 1'b0;
        end else begin
            settle_q <= settle_d;
            layer_q  <= layer_d;
            down_q   <= down_d;
        end
    end

endmodule

// File: rtl/fc_chain_ctrl.sv
// Sequencer driving forward then optional reverse backward strobes through a chain of fc layers.
module fc_chain_ctrl
    import fc_pkg::*;
#(
    parameter int LAYERS = 4,
    parameter int W      = 9,
    parameter int SETTLE = 2
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       start_in,
    input  logic                       mode_in,
    input  logic                       abort_in,
    input  logic [W-1:0]               x_in,
    input  logic [W-1:0]               y_in,
    output logic                       ready_out,
    output logic [W-1:0]               fin_out,
    output logic [LAYERS-1:0]          fd_prop_out,
    output logic [LAYERS-1:0]          bk_prop_out,
    output logic                       oscillator_out,
    output logic [$clog2(LAYERS):0]    layer_idx_out,
    output logic [W-1:0]               y_out,
    output logic                       done_out
);

    localparam int                LW  = $clog2(LAYERS) + 1;
    localparam logic [LAYERS-1:0] ONE = LAYERS'(1);

    fc_state_t     state_q, state_d;
    fc_mode_t      mode_q, mode_d;
    logic [W-1:0]  fin_q, fin_d;
    logic [W-1:0]  y_q, y_d;
    logic          osc_q, osc_d;
    logic          cnt_load, cnt_down, cnt_en, last_step, busy_prop;
    logic [LW-1:0] layer;

    layer_step_counter #(
        .LAYERS (LAYERS),
        .SETTLE (SETTLE),
        .LW     (LW)
    ) u_step (
        .clk_i       (clk_in),
        .rst_ni      (rst_in),
        .load_i      (cnt_load),
        .down_i      (cnt_down),
        .en_i        (cnt_en),
        .layer_o     (layer),
        .last_step_o (last_step)
    );

    assign busy_prop = (state_q == FWD) || (state_q == BWD);
    assign cnt_en    = busy_prop;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        fin_d    = fin_q;
        y_d      = y_q;
        cnt_load = 1'b0;
        cnt_down = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_in && !abort_in) begin
                    state_d  = FWD;
                    mode_d   = fc_mode_t'(mode_in);
                    fin_d    = x_in;
                    cnt_load = 1'b1;
                end
            end
            FWD: begin
                if (abort_in) begin
                    state_d = IDLE;
                end else if (last_step) begin
                    y_d = y_in;
                    if (mode_q == TRAIN) begin
                        state_d  = BWD;
                        cnt_load = 1'b1;
                        cnt_down = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            BWD: begin
                if (abort_in)       state_d = IDLE;
                else if (last_step) state_d = DONE;
            end
            DONE: state_d = IDLE;
        endcase
        // Clearing on the way into IDLE makes every job's first busy cycle read 1.
        osc_d = (state_d == IDLE) ? 1'b0 : ~osc_q;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            mode_q  <= INFER;
            fin_q   <= '0;
            y_q     <= '0;
            osc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            fin_q   <= fin_d;
            y_q     <= y_d;
            osc_q   <= osc_d;
        end
    end

    assign ready_out      = (state_q == IDLE);
    assign done_out       = (state_q == DONE);
    assign fin_out        = fin_q;
    assign y_out          = y_q;
    assign oscillator_out = osc_q;
    assign fd_prop_out    = (state_q == FWD) ? (ONE << layer) : '0;
    assign bk_prop_out    = (state_q == BWD) ? (ONE << layer) : '0;
    assign layer_idx_out  = busy_prop ? layer : '0;

endmodule

// File: tb/tb_fc_chain_ctrl.sv
// Self-checking bench: job-cycle model compared every cycle, plus directed literal checks.
module tb_fc_chain_ctrl;

    localparam int L1 = 4, S1 = 2, L2 = 1, S2 = 1, W = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic         start1 = 0, mode1 = 0, abort1 = 0;
    logic [W-1:0] x1 = '0, yin1 = '0;
    logic         ready1, osc1, done1;
    logic [W-1:0] fin1, y1;
    logic [3:0]   fd1, bk1;
    logic [2:0]   idx1;

    logic         start2 = 0, mode2 = 0, abort2 = 0;
    logic [W-1:0] x2 = '0, yin2 = 9'h1C7;
    logic         ready2, osc2, done2;
    logic [W-1:0] fin2, y2;
    logic [0:0]   fd2, bk2;
    logic [0:0]   idx2;

    fc_chain_ctrl #(.LAYERS(L1), .W(W), .SETTLE(S1)) dut1 (
        .clk_in(clk), .rst_in(rst), .start_in(start1), .mode_in(mode1), .abort_in(abort1),
        .x_in(x1), .y_in(yin1), .ready_out(ready1), .fin_out(fin1), .fd_prop_out(fd1),
        .bk_prop_out(bk1), .oscillator_out(osc1), .layer_idx_out(idx1), .y_out(y1),
        .done_out(done1)
    );

    fc_chain_ctrl #(.LAYERS(L2), .W(W), .SETTLE(S2)) dut2 (
        .clk_in(clk), .rst_in(rst), .start_in(start2), .mode_in(mode2), .abort_in(abort2),
        .x_in(x2), .y_in(yin2), .ready_out(ready2), .fin_out(fin2), .fd_prop_out(fd2),
        .bk_prop_out(bk2), .oscillator_out(osc2), .layer_idx_out(idx2), .y_out(y2),
        .done_out(done2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: c counts cycles since the accept edge (0 = idle); outputs derive from c alone.
    function automatic int end_c(bit tr, int l, int s);
        return tr ? 2 * l * s : l * s;
    endfunction
    function automatic int exp_fd(int c, int l, int s);
        return (c >= 1 && c <= l * s) ? (1 << ((c - 1) / s)) : 0;
    endfunction
    function automatic int exp_bk(int c, bit tr, int l, int s);
        return (tr && c > l * s && c <= 2 * l * s) ? (1 << (l - 1 - (c - l * s - 1) / s)) : 0;
    endfunction
    function automatic int exp_idx(int c, bit tr, int l, int s);
        if (c >= 1 && c <= l * s) return (c - 1) / s;
        if (tr && c > l * s && c <= 2 * l * s) return l - 1 - (c - l * s - 1) / s;
        return 0;
    endfunction

    int           c1 = 0, c2 = 0;
    bit           tr1 = 0, tr2 = 0;
    logic [W-1:0] mfin1 = '0, my1 = '0, mfin2 = '0, my2 = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            c1 <= 0; tr1 <= 0; mfin1 <= '0; my1 <= '0;
        end else if (c1 == 0) begin
            if (start1 && !abort1) begin c1 <= 1; tr1 <= mode1; mfin1 <= x1; end
        end else if (abort1) begin
            c1 <= 0;
        end else begin
            if (c1 == L1 * S1) my1 <= yin1;
            c1 <= (c1 == end_c(tr1, L1, S1) + 1) ? 0 : c1 + 1;
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            c2 <= 0; tr2 <= 0; mfin2 <= '0; my2 <= '0;
        end else if (c2 == 0) begin
            if (start2 && !abort2) begin c2 <= 1; tr2 <= mode2; mfin2 <= x2; end
        end else if (abort2) begin
            c2 <= 0;
        end else begin
            if (c2 == L2 * S2) my2 <= yin2;
            c2 <= (c2 == end_c(tr2, L2, S2) + 1) ? 0 : c2 + 1;
        end
    end

    always @(negedge clk) begin
        check("m1_ready", ready1, c1 == 0);
        check("m1_done",  done1,  c1 == end_c(tr1, L1, S1) + 1);
        check("m1_fd",    fd1,    exp_fd(c1, L1, S1));
        check("m1_bk",    bk1,    exp_bk(c1, tr1, L1, S1));
        check("m1_idx",   idx1,   exp_idx(c1, tr1, L1, S1));
        check("m1_osc",   osc1,   c1 % 2);
        check("m1_fin",   fin1,   mfin1);
        check("m1_y",     y1,     my1);
        check("m2_ready", ready2, c2 == 0);
        check("m2_done",  done2,  c2 == end_c(tr2, L2, S2) + 1);
        check("m2_fd",    fd2,    exp_fd(c2, L2, S2));
        check("m2_bk",    bk2,    exp_bk(c2, tr2, L2, S2));
        check("m2_idx",   idx2,   exp_idx(c2, tr2, L2, S2));
        check("m2_osc",   osc2,   c2 % 2);
        check("m2_fin",   fin2,   mfin2);
        check("m2_y",     y2,     my2);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic accept1(input logic [W-1:0] x, input logic m);
        x1 = x; mode1 = m; start1 = 1'b1;
        step(1);
        start1 = 1'b0;
    endtask

    logic [3:0] fd_seq [8] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000};
    logic [3:0] bk_seq [8] = '{4'b1000, 4'b1000, 4'b0100, 4'b0100, 4'b0010, 4'b0010, 4'b0001, 4'b0001};
    int dones;

    initial begin
        #2 rst = 1'b0;
        step(2);
        check("rst_ready", ready1, 1);
        check("rst_fd", fd1, 0);
        check("rst_osc", osc1, 0);
        check("rst_done", done1, 0);
        rst = 1'b1;
        step(2);

        // Inference job
        yin1 = 9'h155;
        accept1(9'h1A5, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check("inf_fd_seq", fd1, fd_seq[i]);
            check("inf_bk_zero", bk1, 0);
            step(1);
        end
        check("inf_done_c9", done1, 1);
        check("inf_ready_c9", ready1, 0);
        step(1);
        check("inf_ready_c10", ready1, 1);
        check("inf_done_c10", done1, 0);
        check("inf_fin", fin1, 9'h1A5);
        check("inf_y", y1, 9'h155);

        // Train job; y_in only valid in the last FWD cycle
        yin1 = 9'h000;
        accept1(9'h0C3, 1'b1);
        step(7);
        yin1 = 9'h0F3;
        step(1);
        yin1 = 9'h0AA;
        for (int i = 0; i < 8; i++) begin
            check("trn_bk_seq", bk1, bk_seq[i]);
            check("trn_fd_zero", fd1, 0);
            step(1);
        end
        check("trn_done_c17", done1, 1);
        step(1);
        check("trn_ready_c18", ready1, 1);
        check("trn_y", y1, 9'h0F3);

        // Abort in cycle 5 of an inference job
        yin1 = 9'h011;
        accept1(9'h02D, 1'b0);
        step(4);
        abort1 = 1'b1;
        step(1);
        abort1 = 1'b0;
        check("abt_ready", ready1, 1);
        check("abt_fd", fd1, 0);
        check("abt_done", done1, 0);
        check("abt_osc", osc1, 0);
        check("abt_y", y1, 9'h0F3);
        step(3);

        // Start and abort together in IDLE
        start1 = 1'b1; abort1 = 1'b1;
        step(1);
        check("sa_ready", ready1, 1);
        check("sa_fd", fd1, 0);
        start1 = 1'b0; abort1 = 1'b0;
        step(1);

        // Start held while busy: one job only
        dones = 0;
        x1 = 9'h07E; mode1 = 1'b0; start1 = 1'b1;
        step(1);
        for (int i = 1; i <= 9; i++) begin
            if (done1) dones++;
            step(1);
        end
        start1 = 1'b0;
        check("busy_ready_c10", ready1, 1);
        for (int i = 0; i < 12; i++) begin
            if (done1) dones++;
            step(1);
        end
        check("busy_one_done", dones, 1);

        // LAYERS=1, SETTLE=1 train corner
        x2 = 9'h101; mode2 = 1'b1; start2 = 1'b1;
        step(1);
        start2 = 1'b0;
        check("c_fd_c1", fd2, 1);
        check("c_osc_c1", osc2, 1);
        step(1);
        check("c_bk_c2", bk2, 1);
        check("c_fd_c2", fd2, 0);
        check("c_osc_c2", osc2, 0);
        step(1);
        check("c_done_c3", done2, 1);
        check("c_osc_c3", osc2, 1);
        step(1);
        check("c_ready_c4", ready2, 1);
        check("c_y", y2, 9'h1C7);

        // Async reset mid-BWD
        yin1 = 9'h033;
        accept1(9'h0FF, 1'b1);
        step(10);
        check("ar_in_bwd", bk1 != 0, 1);
        #2 rst = 1'b0;
        #1;
        check("ar_ready", ready1, 1);
        check("ar_bk", bk1, 0);
        check("ar_fd", fd1, 0);
        check("ar_osc", osc1, 0);
        check("ar_idx", idx1, 0);
        check("ar_fin", fin1, 0);
        check("ar_y", y1, 0);
        check("ar_done", done1, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        step(3);
        check("ar_ready_after", ready1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
